// File: rtl/bram_ctrl.sv
// ---------------------------------------------------------------------------
// bram_ctrl
//
// Single-port block memory with a request/response handshake, byte-enabled
// writes, registered read data, out-of-range detection and a hardware clear
// sequencer that writes INIT_VALUE to every word after reset or on clr.
//
// Parameters
//   DATA_WIDTH  word width in bits (multiple of 8)
//   DEPTH       number of words (any value >= 2, not necessarily a power of 2)
//   ADDR_WIDTH  request address width, $clog2(DEPTH)
//   INIT_VALUE  word written to every location by the clear sequencer
//
// Ports
//   ck         clock, rising edge
//   rst        synchronous active-high reset; restarts the clear sequence
//   clr        single-cycle pulse, starts a full-array clear (ignored mid-clear)
//   req_valid  request present
//   req_ready  request can be accepted this cycle (RUN and no clr)
//   req_wen    1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  read data valid, one-cycle pulse per accepted read
//   rsp_rdata  read data, holds while rsp_valid is low
//   addr_err   one-cycle pulse: the accepted request was out of range
//   busy       clear sequence in progress
//
// Optional build macro
//   BRAM_OUTREG_EN  adds an output register stage; rsp_valid, rsp_rdata and
//                   addr_err move together to a read latency of 2.
// ---------------------------------------------------------------------------
module bram_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    addr_err,
  output logic                    busy
);

  localparam int BE_W = DATA_WIDTH / 8;

  // Last valid word; the clear pointer stops here before switching to RUN.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // DEPTH in one extra bit so a power-of-two DEPTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   ptr_d;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_p0;
  logic                    ok_p0;
  logic                    rd_p0;
  logic                    wr_p0;

  logic                    vld_p1;
  logic                    err_p1;
  logic [DATA_WIDTH-1:0]   rdata_p1;

  // True when the word address lies inside the array.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  // -------------------------------------------------------------------------
  // Control FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state and control outputs. In CLEAR the pointer saturates at the
  // last word on the cycle the FSM returns to RUN, so it never wraps.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_we    = 1'b0;
    busy      = 1'b1;
    req_ready = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        busy      = 1'b0;
        req_ready = !clr;
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage p0: request acceptance and decode
  // -------------------------------------------------------------------------
  always_comb begin
    acc_p0 = req_valid && req_ready;
    ok_p0  = addr_in_range(req_addr);
    rd_p0  = acc_p0 && !req_wen;
    wr_p0  = acc_p0 && req_wen && ok_p0;
  end

  // Storage array. The clear sequencer and the request path never write in
  // the same cycle because req_ready is low throughout CLEAR.
  always_ff @(posedge ck) begin
    if (clr_we) begin
      mem[ptr_q] <= INIT_VALUE;
    end else if (wr_p0) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: registered read data and status
  // -------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_p0;
      err_p1 <= acc_p0 && !ok_p0;
      // Only a read updates the data register, so it holds between reads.
      if (rd_p0) begin
        rdata_p1 <= ok_p0 ? mem[req_addr] : '0;
      end
    end
  end

`ifdef BRAM_OUTREG_EN
  logic                  vld_p2;
  logic                  err_p2;
  logic [DATA_WIDTH-1:0] rdata_p2;

  // -------------------------------------------------------------------------
  // Stage p2: optional output register
  // -------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      rdata_p2 <= '0;
    end else begin
      vld_p2   <= vld_p1;
      err_p2   <= err_p1;
      rdata_p2 <= rdata_p1;
    end
  end

  assign rsp_valid = vld_p2;
  assign addr_err  = err_p2;
  assign rsp_rdata = rdata_p2;
`else
  assign rsp_valid = vld_p1;
  assign addr_err  = err_p1;
  assign rsp_rdata = rdata_p1;
`endif

endmodule

// File: tb/tb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_ctrl
//
// Directed bench for bram_ctrl. Two instances share all inputs: u_a with
// DEPTH=256 and u_b with DEPTH=200, both INIT_VALUE=32'hDEADBEEF, so that the
// same stimulus covers the power-of-two array and the out-of-range path.
// ---------------------------------------------------------------------------
module tb_bram_ctrl;

`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] INIT = 32'hDEADBEEF;

  logic        ck = 1'b0;
  logic        rst;
  logic        clr;
  logic        req_valid;
  logic        req_wen;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        ready_a, vld_a, err_a, busy_a;
  logic [31:0] rdata_a;
  logic        ready_b, vld_b, err_b, busy_b;
  logic [31:0] rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 ck = ~ck;

  bram_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .INIT_VALUE(INIT)) u_a (
    .ck(ck), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(ready_a), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_a), .rsp_rdata(rdata_a), .addr_err(err_a), .busy(busy_a)
  );

  bram_ctrl #(.DATA_WIDTH(32), .DEPTH(200), .INIT_VALUE(INIT)) u_b (
    .ck(ck), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(ready_b), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_b), .rsp_rdata(rdata_b), .addr_err(err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Present one request for a single accept edge, then go idle and wait
  // until the response (if any) is visible.
  task automatic do_req(input logic wen, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_wen   = 1'b0;
    repeat (LAT - 1) step();
  endtask

  // Count busy cycles of both instances from now, with a cycle bound.
  task automatic count_busy(output int ca, output int cb, output int sv);
    int n;
    ca = 0; cb = 0; sv = 0; n = 0;
    while ((busy_a || busy_b) && n < 2000) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (vld_a || vld_b) sv++;
      step();
      n++;
    end
  endtask

  initial begin
    int ca, cb, sv;
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset state
    step();
    chk("rst_busy",  32'(busy_a),  32'd1);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_vld",   32'(vld_a),   32'd0);
    chk("rst_rdata", rdata_a,      32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    rst = 1'b0;

    // Reset clear duration
    count_busy(ca, cb, sv);
    chk("clear_len_a", 32'(ca), 32'd256);
    chk("clear_len_b", 32'(cb), 32'd200);
    chk("clear_no_vld", 32'(sv), 32'd0);
    chk("run_ready", 32'(ready_a), 32'd1);

    // Cleared contents
    do_req(1'b0, 8'd0, '0, '0);
    chk("rd0_vld", 32'(vld_a), 32'd1);
    chk("rd0_data", rdata_a, INIT);
    do_req(1'b0, 8'd17, '0, '0);
    chk("rd17_data", rdata_a, INIT);
    chk("rd17_data_b", rdata_b, INIT);
    do_req(1'b0, 8'd255, '0, '0);
    chk("rd255_data", rdata_a, INIT);
    chk("rd255_err_a", 32'(err_a), 32'd0);
    chk("rd255_b_oor_data", rdata_b, 32'd0);
    chk("rd255_b_oor_err", 32'(err_b), 32'd1);
    chk("rd255_b_oor_vld", 32'(vld_b), 32'd1);

    // Byte enables
    do_req(1'b1, 8'd5, 32'h11223344, 4'hF);
    chk("wr_no_vld", 32'(vld_a), 32'd0);
    do_req(1'b1, 8'd5, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 8'd5, '0, '0);
    chk("be_merge", rdata_a, 32'h11BB33DD);
    do_req(1'b1, 8'd5, 32'hFFFFFFFF, 4'h0);
    do_req(1'b0, 8'd5, '0, '0);
    chk("be_zero_noop", rdata_a, 32'h11BB33DD);
    step();
    chk("hold_vld", 32'(vld_a), 32'd0);
    chk("hold_rdata", rdata_a, 32'h11BB33DD);

    // Read immediately after a write to the same address
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 8'd9;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    step();
    req_wen = 1'b0;
    step();
    req_valid = 1'b0;
    repeat (LAT - 1) step();
    chk("raw_vld", 32'(vld_a), 32'd1);
    chk("raw_data", rdata_a, 32'hCAFEF00D);

    // Streaming: write addr*3, then eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 8'(i);
      req_wdata = 32'(i * 3); req_be = 4'hF;
      step();
    end
    req_valid = 1'b0; req_wen = 1'b0;
    step();
    for (int k = 0; k < 8 + LAT - 1; k++) begin
      int j;
      if (k < 8) begin
        req_valid = 1'b1; req_addr = 8'(k);
      end else begin
        req_valid = 1'b0;
      end
      step();
      j = k - LAT + 1;
      if (j >= 0) begin
        chk($sformatf("stream_vld%0d", j), 32'(vld_a), 32'd1);
        chk($sformatf("stream_data%0d", j), rdata_a, 32'(j * 3));
        chk($sformatf("stream_data_b%0d", j), rdata_b, 32'(j * 3));
      end
    end
    req_valid = 1'b0;
    step();
    chk("stream_end_vld", 32'(vld_a), 32'd0);

    // Out of range on the 200-word instance
    do_req(1'b1, 8'd200, 32'h1, 4'hF);
    chk("oor_wr_err", 32'(err_b), 32'd1);
    chk("oor_wr_vld", 32'(vld_b), 32'd0);
    chk("oor_wr_err_a", 32'(err_a), 32'd0);
    step();
    chk("oor_err_pulse", 32'(err_b), 32'd0);
    do_req(1'b0, 8'd200, '0, '0);
    chk("oor_rd_err", 32'(err_b), 32'd1);
    chk("oor_rd_vld", 32'(vld_b), 32'd1);
    chk("oor_rd_data", rdata_b, 32'd0);
    chk("inr_a_wr200", rdata_a, 32'h1);
    do_req(1'b0, 8'd199, '0, '0);
    chk("rd199_err", 32'(err_b), 32'd0);
    chk("rd199_data", rdata_b, INIT);

    // Clear collides with a read request
    step();
    clr = 1'b1; req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'd9;
    #1;
    chk("coll_ready", 32'(ready_a), 32'd0);
    step();
    clr = 1'b0; req_valid = 1'b0;
    count_busy(ca, cb, sv);
    chk("coll_len_a", 32'(ca), 32'd256);
    chk("coll_len_b", 32'(cb), 32'd200);
    chk("coll_no_vld", 32'(sv), 32'd0);
    do_req(1'b0, 8'd9, '0, '0);
    chk("coll_data9", rdata_a, INIT);
    do_req(1'b0, 8'd5, '0, '0);
    chk("coll_data5", rdata_a, INIT);

    // Reset in the middle of a clear
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (99) step();
    chk("mid_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(ca, cb, sv);
    chk("midrst_len_a", 32'(ca), 32'd256);
    chk("midrst_len_b", 32'(cb), 32'd200);
    chk("midrst_no_vld", 32'(sv), 32'd0);
    do_req(1'b0, 8'd3, '0, '0);
    chk("midrst_data3", rdata_a, INIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_ctrl.md
Name: bram_ctrl

Overview:
Parametrised single-port block memory with a request/response handshake, byte-enabled writes and a hardware clear sequencer. It is the successor to the plain block ROM/RAM: registered read data, out-of-range detection, and a busy indication while the array is being initialised. It sits between the core's load/store path and on-chip storage.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH, 256, number of words; need not be a power of two.
ADDR_WIDTH, $clog2(DEPTH), request address width.
INIT_VALUE, 0, word written to every location by the clear sequencer.

Ports:
ck  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  single-cycle pulse; starts a full-array clear.
req_valid  input  1  request present.
req_ready  output  1  request can be accepted this cycle.
req_wen  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
req_be  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
rsp_valid  output  1  read data valid; single-cycle pulse.
rsp_rdata  output  DATA_WIDTH  read data.
addr_err  output  1  previous accepted request was out of range; single-cycle pulse.
busy  output  1  clear sequence in progress.

Behaviour:
- Interface: one clock, ck; reset rst is synchronous and active-high.
- Reset values: busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, addr_err=0, FSM=CLEAR, clear pointer=0.
- FSM states:
  - CLEAR: writes INIT_VALUE to address ptr and increments ptr every cycle. Leaves for RUN after writing address DEPTH-1, so the clear takes exactly DEPTH cycles. busy=1 and req_ready=0 throughout.
  - RUN: busy=0. req_ready = !clr (combinational).
- Leaving RUN: clr=1 in RUN moves the FSM to CLEAR with ptr=0 on the next edge. A request presented in the same cycle is not accepted.
- clr in CLEAR is ignored; the clear continues.
- rst in any state, including mid-clear, restarts CLEAR from ptr=0. Pending rsp_valid/addr_err are squashed to 0.
- Accept: a request is accepted on an edge where req_valid && req_ready. There is at most one accepted request per cycle and no internal queue.
- Write:
  - Bytes with req_be[i]=1 are updated at the accept edge; all other bytes are preserved.
  - req_be=0 is a legal no-op.
  - Writes produce no rsp_valid.
- Read:
  - Latency 1: rsp_valid=1 and rsp_rdata=mem[addr] in the cycle after the accept edge.
  - Back-to-back reads deliver one response per cycle.
  - rsp_rdata holds its last value while rsp_valid=0.
  - The response is not back-pressured; the requester must sink it.
- Read after write to the same address in the next cycle returns the newly written bytes.
- Out of range (req_addr >= DEPTH):
  - A write is dropped with the array unchanged.
  - A read returns rsp_rdata=0 with rsp_valid=1.
  - In both cases addr_err=1 for one cycle, the cycle after the accept edge.
- No wrap-around of addresses; the clear pointer saturates at DEPTH-1 before the state change.

Optional Feature:
BRAM_OUTREG_EN: when defined, adds an output pipeline register.
- Read latency becomes 2; rsp_valid, rsp_rdata and addr_err are all delayed one extra cycle together.
- The extra stage is cleared to 0 by rst.
- Throughput stays one request per cycle.
When undefined, latency is 1 as described above.

Test Plan:
- Reset clear: assert rst for 1 cycle with DEPTH=256, INIT_VALUE=32'hDEADBEEF -> busy=1 for exactly 256 cycles; then read addr 0, 17 and 255 -> rsp_rdata=32'hDEADBEEF one cycle after accept.
- Byte enables: write 32'h11223344 with be=4'hF to addr 5, then write 32'hAABBCCDD with be=4'b0101, then read addr 5 -> rsp_rdata=32'h11BB33DD.
- Streaming: with DEPTH=256, issue reads to addr 0..7 on 8 consecutive cycles after writing addr*3 to each -> rsp_valid high for 8 consecutive cycles with data 0,3,...,21 in order.
- Out of range: with DEPTH=200, write 32'h1 to addr 200, then read addr 200 -> addr_err pulses after each request; the read returns rsp_rdata=0; a subsequent read of addr 199 returns its prior value with addr_err=0.
- Clear collision: with DEPTH=256, pulse clr together with req_valid=1 in RUN -> req_ready=0 and the request is not accepted; busy=1 for 256 cycles; memory returns INIT_VALUE afterwards.
- Reset mid-clear: with DEPTH=256, assert rst at clear cycle 100 -> busy stays high for a further 256 cycles from the rst edge; rsp_valid=0 throughout.
